// File: rtl/serial_alu_pkg.sv
// Shared types and constants for the bit-serial ALU sequencer and its 1-bit slice.
package serial_alu_pkg;

  typedef enum logic [2:0] {
    ARITH_ADD  = 3'b000,
    ARITH_SUB  = 3'b001,
    ARITH_INC  = 3'b010,
    ARITH_DEC  = 3'b011,
    ARITH_ADC  = 3'b100,
    ARITH_SBB  = 3'b101,
    ARITH_PASS = 3'b110,
    ARITH_RSVD = 3'b111
  } arith_op_e;

  typedef enum logic [2:0] {
    LOGIC_AND  = 3'b000,
    LOGIC_OR   = 3'b001,
    LOGIC_XOR  = 3'b010,
    LOGIC_NAND = 3'b011,
    LOGIC_NOR  = 3'b100,
    LOGIC_XNOR = 3'b101,
    LOGIC_NOT  = 3'b110,
    LOGIC_PASS = 3'b111
  } logic_op_e;

  localparam logic MODE_ARITH = 1'b0;
  localparam logic MODE_LOGIC = 1'b1;

  localparam logic [2:0] OPSEL_RESERVED = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_alu_bit.sv
// Combinational 1-bit ALU slice: full adder in arithmetic mode, bitwise ops in logic mode.
module serial_alu_bit
  import serial_alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic [2:0] opsel,
  input  logic       mode,
  output logic       s,
  output logic       cnext
);

  // NOTE: every output gets a default first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    s     = 1'b0;
    cnext = 1'b0;
    if (mode == MODE_ARITH) begin
      // The sequencer has already shaped b and the initial carry; only the reserved op is special here.
      if (opsel != OPSEL_RESERVED) begin
        s     = a ^ b ^ c;
        cnext = (a & b) | (a & c) | (b & c);
      end
    end else begin
      case (opsel)
        LOGIC_AND:  s = a & b;
        LOGIC_OR:   s = a | b;
        LOGIC_XOR:  s = a ^ b;
        LOGIC_NAND: s = ~(a & b);
        LOGIC_NOR:  s = ~(a | b);
        LOGIC_XNOR: s = ~(a ^ b);
        LOGIC_NOT:  s = ~a;
        default:    s = a;
      endcase
    end
  end

endmodule

// File: rtl/serial_alu_sequencer.sv
// Bit-serial multi-bit ALU: processes operands LSB-first through serial_alu_bit, one bit per clock.
// Optional flag outputs (zero/neg/ovf) are built when SERIAL_ALU_FLAGS_EN is defined.
module serial_alu_sequencer
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_op1,
  input  logic [WIDTH-1:0] in_op2,
  input  logic             in_cin,
  input  logic [2:0]       in_opsel,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_cout
`ifdef SERIAL_ALU_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovf
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state, state_next;
  logic             load, step, last;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] res_sr;
  logic [WIDTH-1:0] res_cat;
  logic [2:0]       opsel_q;
  logic             mode_q;
  logic             carry_q;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] b_init;
  logic             c0;
  logic             s, cnext;

  // Effective second operand and initial carry, resolved once at accept time.
  always_comb begin
    b_init = in_op2;
    c0     = 1'b0;
    if (in_mode == MODE_ARITH) begin
      case (in_opsel)
        ARITH_ADD:  begin b_init = in_op2;  c0 = 1'b0;   end
        ARITH_SUB:  begin b_init = ~in_op2; c0 = 1'b1;   end
        ARITH_INC:  begin b_init = '0;      c0 = 1'b1;   end
        ARITH_DEC:  begin b_init = '1;      c0 = 1'b0;   end
        ARITH_ADC:  begin b_init = in_op2;  c0 = in_cin; end
        ARITH_SBB:  begin b_init = ~in_op2; c0 = in_cin; end
        default:    begin b_init = '0;      c0 = 1'b0;   end
      endcase
    end
  end

  serial_alu_bit u_bit (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .c     (carry_q),
    .opsel (opsel_q),
    .mode  (mode_q),
    .s     (s),
    .cnext (cnext)
  );

  assign last    = (count == CNT_W'(WIDTH - 1));
  assign res_cat = {s, res_sr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid && in_ready) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the shift registers are reset too, so an aborted operation leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      opsel_q    <= '0;
      mode_q     <= MODE_ARITH;
      carry_q    <= 1'b0;
      count      <= '0;
      out_result <= '0;
      out_cout   <= 1'b0;
    end else if (load) begin
      a_sr    <= in_op1;
      b_sr    <= (in_mode == MODE_ARITH) ? b_init : in_op2;
      opsel_q <= in_opsel;
      mode_q  <= in_mode;
      carry_q <= c0;
      count   <= '0;
    end else if (step) begin
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      res_sr  <= res_cat[WIDTH-1:1];
      carry_q <= cnext;
      count   <= count + 1'b1;
      if (last) begin
        out_result <= res_cat;
        out_cout   <= cnext;
      end
    end
  end

`ifdef SERIAL_ALU_FLAGS_EN
  // carry_q holds the carry into the MSB while the last bit is evaluated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_zero <= 1'b0;
      out_neg  <= 1'b0;
      out_ovf  <= 1'b0;
    end else if (step && last) begin
      out_zero <= (res_cat == '0);
      out_neg  <= s;
      out_ovf  <= (mode_q == MODE_ARITH) ? (carry_q ^ cnext) : 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Directed self-checking bench for serial_alu_sequencer (WIDTH=8); flag checks follow SERIAL_ALU_FLAGS_EN.
module tb_serial_alu_sequencer;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_op1;
  logic [WIDTH-1:0] in_op2;
  logic             in_cin;
  logic [2:0]       in_opsel;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_cout;
`ifdef SERIAL_ALU_FLAGS_EN
  logic             out_zero;
  logic             out_neg;
  logic             out_ovf;
`endif

  int checks   = 0;
  int failures = 0;

  serial_alu_sequencer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op1     (in_op1),
    .in_op2     (in_op2),
    .in_cin     (in_cin),
    .in_opsel   (in_opsel),
    .in_mode    (in_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_cout   (out_cout)
`ifdef SERIAL_ALU_FLAGS_EN
    ,
    .out_zero   (out_zero),
    .out_neg    (out_neg),
    .out_ovf    (out_ovf)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Issue one operation, scramble the inputs after accept, wait for the result, optionally
  // hold backpressure while pulsing in_valid, then retire it.
  task automatic run_op(input string tag, input logic [7:0] op1, input logic [7:0] op2,
                        input logic cin, input logic [2:0] opsel, input logic mode,
                        input logic [7:0] exp_res, input logic exp_cout,
                        input logic exp_zero, input logic exp_neg, input logic exp_ovf,
                        input int hold);
    int   cycles;
    logic busy_ready;
    @(negedge clk);
    check({tag, "_ready_idle"}, 32'(in_ready), 32'd1);
    in_op1   = op1;
    in_op2   = op2;
    in_cin   = cin;
    in_opsel = opsel;
    in_mode  = mode;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid   = 1'b0;
    in_op1     = ~op1;
    in_op2     = ~op2;
    in_cin     = ~cin;
    in_opsel   = ~opsel;
    in_mode    = ~mode;
    cycles     = 0;
    busy_ready = 1'b0;
    while (out_valid !== 1'b1 && cycles < 3 * WIDTH) begin
      busy_ready = busy_ready | in_ready;
      @(negedge clk);
      cycles++;
    end
    busy_ready = busy_ready | in_ready;
    check({tag, "_latency"}, 32'(cycles), 32'(WIDTH));
    check({tag, "_ready_busy"}, 32'(busy_ready), 32'd0);
    check({tag, "_result"}, 32'(out_result), 32'(exp_res));
    check({tag, "_cout"}, 32'(out_cout), 32'(exp_cout));
`ifdef SERIAL_ALU_FLAGS_EN
    check({tag, "_zero"}, 32'(out_zero), 32'(exp_zero));
    check({tag, "_neg"}, 32'(out_neg), 32'(exp_neg));
    check({tag, "_ovf"}, 32'(out_ovf), 32'(exp_ovf));
`else
    if (exp_zero !== (exp_res == 8'h00) || exp_neg !== exp_res[7] || exp_ovf === 1'bx)
      $display("note: %s flag expectations inconsistent", tag);
`endif
    for (int i = 0; i < hold; i++) begin
      in_valid = ~i[0];
      in_op1   = 8'(i * 37);
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_result"}, 32'(out_result), 32'(exp_res));
      check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_retire_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_retire_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op1    = '0;
    in_op2    = '0;
    in_cin    = 1'b0;
    in_opsel  = '0;
    in_mode   = 1'b0;
    out_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(out_result), 32'd0);
    check("rst_cout", 32'(out_cout), 32'd0);
    rst = 1'b0;
    #1;
    check("rel_ready", 32'(in_ready), 32'd1);

    //      tag         op1    op2    cin   opsel   mode  result cout zero neg ovf hold
    run_op("add_wrap",  8'hFF, 8'h01, 1'b0, 3'b000, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    run_op("sub_neg",   8'h05, 8'h07, 1'b0, 3'b001, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    run_op("sub_eq",    8'h33, 8'h33, 1'b0, 3'b001, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    run_op("adc_cin",   8'h10, 8'h20, 1'b1, 3'b100, 1'b0, 8'h31, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run_op("dec_zero",  8'h00, 8'h55, 1'b0, 3'b011, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    run_op("inc_wrap",  8'hFF, 8'h3C, 1'b1, 3'b010, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    run_op("xor",       8'hA5, 8'h0F, 1'b1, 3'b010, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    run_op("nor",       8'h00, 8'h00, 1'b0, 3'b100, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    run_op("arith_rsv", 8'h5A, 8'h3C, 1'b1, 3'b111, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    run_op("backpress", 8'h12, 8'h34, 1'b0, 3'b000, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0, 1'b0, 5);

    // Abort an ADD at bit 4 with an asynchronous reset.
    @(negedge clk);
    in_op1   = 8'hFF;
    in_op2   = 8'h01;
    in_opsel = 3'b000;
    in_mode  = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_result", 32'(out_result), 32'd0);
    check("abort_cout", 32'(out_cout), 32'd0);
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_rel_ready", 32'(in_ready), 32'd1);
    repeat (WIDTH + 2) @(negedge clk);
    check("abort_no_result", 32'(out_valid), 32'd0);

    run_op("add_ovf",   8'h7F, 8'h01, 1'b0, 3'b000, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
